// File: rtl/alu_issue_queue.sv
// Tagged ALU request FIFO feeding a combinational alu, with a registered result slot.
// Optional signed-overflow flag is built only when ALU_OVF_EN is defined.

module alu (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUop,
  output logic [31:0] C
);
  always_comb begin
    C = '0;
    case (ALUop)
      3'b000:  C = A + B;
      3'b001:  C = A - B;
      3'b010:  C = A & B;
      3'b011:  C = A | B;
      3'b100:  C = A >> B[4:0];
      3'b101:  C = 32'($signed(A) >>> B[4:0]);
      default: C = '0;
    endcase
  end
endmodule

module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_c,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic [CNT_W-1:0] fifo_cnt
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      a_mem   [DEPTH];
  logic [31:0]      b_mem   [DEPTH];
  logic [2:0]       op_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop, fifo_empty;
  logic [31:0]      head_a, head_b, alu_c;
  logic [2:0]       head_op;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is registered-state only (fifo_cnt), so a full FIFO refuses a
  // push even in a cycle that pops; the slot reloads whenever it is empty or
  // being drained in the same cycle.
  assign in_ready   = (fifo_cnt != CNT_W'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = in_valid && in_ready;
  assign pop        = !fifo_empty && (!out_valid || out_ready);

  assign head_a  = a_mem[rd_ptr];
  assign head_b  = b_mem[rd_ptr];
  assign head_op = op_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr]   <= in_a;
      b_mem[wr_ptr]   <= in_b;
      op_mem[wr_ptr]  <= in_op;
      tag_mem[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  alu u_alu (
    .A     (head_a),
    .B     (head_b),
    .ALUop (head_op),
    .C     (alu_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_tag   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_c     <= alu_c;
      out_tag   <= tag_mem[rd_ptr];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_OVF_EN
  logic head_ovf;

  // Overflow is judged against the sign of A for both add and subtract.
  always_comb begin
    head_ovf = 1'b0;
    case (head_op)
      3'b000:  head_ovf = (head_a[31] == head_b[31]) && (alu_c[31] != head_a[31]);
      3'b001:  head_ovf = (head_a[31] != head_b[31]) && (alu_c[31] != head_a[31]);
      default: head_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_ovf <= 1'b0;
    else if (pop) out_ovf <= head_ovf;
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized and directed bench for alu_issue_queue with a result scoreboard
// fed by an arithmetic reference model.

module tb_alu_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = 3;
  localparam int EW    = 1 + TAG_W + 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [2:0]       in_op = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_c;
  logic [TAG_W-1:0] out_tag;
  logic             out_ovf;
  logic [CNT_W-1:0] fifo_cnt;

  int tests_run = 0;
  int fails = 0;

  logic [EW-1:0] exp_q[$];

  logic             prev_stall = 1'b0;
  logic [31:0]      prev_c;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_ovf;

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  // Reference: result from the opcode table, overflow from exact 64-bit math.
  function automatic logic [EW-1:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] op, input logic [TAG_W-1:0] tag);
    logic [31:0] c;
    logic [31:0] ones;
    logic [4:0]  s;
    longint      sa, sb, exact;
    logic        ovf;
    s    = b[4:0];
    ones = 32'hffff_ffff;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ovf  = 1'b0;
    case (op)
      3'd0: begin exact = sa + sb; c = a + b; ovf = (exact > 64'sd2147483647) || (exact < -64'sd2147483648); end
      3'd1: begin exact = sa - sb; c = a - b; ovf = (exact > 64'sd2147483647) || (exact < -64'sd2147483648); end
      3'd2: c = a & b;
      3'd3: c = a | b;
      3'd4: c = a >> s;
      3'd5: c = (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
      default: c = 32'h0;
    endcase
`ifndef ALU_OVF_EN
    ovf = 1'b0;
`endif
    return {ovf, tag, c};
  endfunction

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_c !== prev_c || out_tag !== prev_tag || out_ovf !== prev_ovf) begin
          fails++;
          $display("FAIL stall_stable: got v=%0b c=%h tag=%0d ovf=%0b, need v=1 c=%h tag=%0d ovf=%0b",
                   out_valid, out_c, out_tag, out_ovf, prev_c, prev_tag, prev_ovf);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL result_unexpected: got c=%h tag=%0d, need no result", out_c, out_tag);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          if ({out_ovf, out_tag, out_c} !== e) begin
            fails++;
            $display("FAIL result: got ovf=%0b tag=%0d c=%h, need ovf=%0b tag=%0d c=%h",
                     out_ovf, out_tag, out_c, e[EW-1], e[EW-2 -: TAG_W], e[31:0]);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) exp_q.push_back(ref_result(in_a, in_b, in_op, in_tag));
      prev_stall = out_valid && !out_ready;
      prev_c     = out_c;
      prev_tag   = out_tag;
      prev_ovf   = out_ovf;
    end
  end

  task automatic push_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [TAG_W-1:0] tag);
    int waited;
    waited   = 0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_tag   = tag;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, need 1", in_ready, waited);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited    = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid !== 1'b0) && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    tests_run++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_timeout: %0d results pending, out_valid=%b, need 0 and 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_c !== 32'h0 || out_tag !== '0 || out_ovf !== 1'b0 ||
        fifo_cnt !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_values: got v=%b c=%h tag=%h ovf=%b cnt=%0d rdy=%b, need 0 0 0 0 0 1",
               out_valid, out_c, out_tag, out_ovf, fifo_cnt, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_check(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                             input logic [TAG_W-1:0] tag, input logic [31:0] exp_c, input logic exp_ovf_on);
    logic exp_ovf;
`ifdef ALU_OVF_EN
    exp_ovf = exp_ovf_on;
`else
    exp_ovf = 1'b0;
`endif
    out_ready = 1'b1;
    push_one(a, b, op, tag);
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: out_valid=%b one edge after push, need 0", out_valid);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_c !== exp_c || out_tag !== tag || out_ovf !== exp_ovf) begin
      fails++;
      $display("FAIL directed op%0d: got v=%b c=%h tag=%0d ovf=%b, need v=1 c=%h tag=%0d ovf=%b",
               op, out_valid, out_c, out_tag, out_ovf, exp_c, tag, exp_ovf);
    end
    drain();
  endtask

  task automatic test_directed();
    issue_check(32'hf000_0000, 32'd4, 3'b101, 4'd3, 32'hff00_0000, 1'b0);
    issue_check(32'hf000_0000, 32'd4, 3'b100, 4'd3, 32'h0f00_0000, 1'b0);
    issue_check(32'h7fff_ffff, 32'd1, 3'b000, 4'd6, 32'h8000_0000, 1'b1);
    issue_check(32'd5,         32'd7, 3'b001, 4'd9, 32'hffff_fffe, 1'b0);
    issue_check(32'h8000_0000, 32'd1, 3'b001, 4'd2, 32'h7fff_ffff, 1'b1);
    issue_check(32'h1234_5678, 32'h0f0f_0f0f, 3'b110, 4'd1, 32'h0, 1'b0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_one($urandom, $urandom, 3'($urandom_range(0, 7)), TAG_W'(i));
    tests_run++;
    if (fifo_cnt !== CNT_W'(DEPTH) || in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd0) begin
      fails++;
      $display("FAIL bp_full: got cnt=%0d rdy=%b v=%b tag=%0d, need cnt=4 rdy=0 v=1 tag=0",
               fifo_cnt, in_ready, out_valid, out_tag);
    end
    in_a = $urandom; in_b = $urandom; in_op = 3'd0; in_tag = 4'd5; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (in_ready !== 1'b0 || fifo_cnt !== CNT_W'(DEPTH) || out_tag !== 4'd0) begin
        fails++;
        $display("FAIL bp_refuse: got rdy=%b cnt=%0d tag=%0d, need rdy=0 cnt=4 tag=0", in_ready, fifo_cnt, out_tag);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_tag !== TAG_W'(i)) begin
        fails++;
        $display("FAIL bp_release: got v=%b tag=%0d, need v=1 tag=%0d", out_valid, out_tag, i);
      end
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_empty: got v=%b, need 0", out_valid);
    end
    drain();
  endtask

  task automatic test_full_refuse();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_one($urandom, $urandom, 3'($urandom_range(0, 7)), TAG_W'(8 + i));
    in_a = $urandom; in_b = $urandom; in_op = 3'd3; in_tag = 4'd13;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_pop_refuse: in_ready=%b, need 0", in_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (fifo_cnt !== 3'd3 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_after_pop: got cnt=%0d rdy=%b, need cnt=3 rdy=1", fifo_cnt, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests_run++;
    if (fifo_cnt !== 3'd3) begin
      fails++;
      $display("FAIL push_pop_cnt: got cnt=%0d, need 3", fifo_cnt);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_one($urandom, $urandom, 3'($urandom_range(0, 7)), TAG_W'(i));
      if (i > 0) begin
        tests_run++;
        if (out_valid !== 1'b1 || fifo_cnt > 3'd1) begin
          fails++;
          $display("FAIL stream_rate: push %0d got v=%b cnt=%0d, need v=1 cnt<=1", i, out_valid, fifo_cnt);
        end
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = $urandom;
      in_b      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      in_op     = 3'($urandom_range(0, 7));
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one($urandom, $urandom, 3'd0, TAG_W'(i + 1));
    tests_run++;
    if (fifo_cnt !== 3'd3 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: got cnt=%0d v=%b, need cnt=3 v=1", fifo_cnt, out_valid);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    tests_run++;
    if (out_valid !== 1'b0 || out_c !== 32'h0 || out_tag !== '0 || out_ovf !== 1'b0 ||
        fifo_cnt !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: got v=%b c=%h tag=%h ovf=%b cnt=%0d rdy=%b, need 0 0 0 0 0 1",
               out_valid, out_c, out_tag, out_ovf, fifo_cnt, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || fifo_cnt !== '0) begin
        fails++;
        $display("FAIL stale_after_reset: got v=%b cnt=%0d, need v=0 cnt=0", out_valid, fifo_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_full_refuse();
    test_back_to_back();
    test_random();
    test_reset_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
